fio_rx_fifo: RTL and testbench

- Input-side buffer for the file I/O peripheral.
- Accepts a byte stream from the host/simulation side using a valid/ready handshake. Stores up to DEPTH bytes.
- Presents the head byte to the peripheral's fio_din/fio_dready inputs. Pops one byte per read-acknowledge pulse on fio_dnxt.
- Lets the host stream input files faster than firmware consumes them, with no byte loss.

---
 rtl/fio_pkg.sv | 15 +
 rtl/fio_byte_fifo.sv | 71 +++++++
 rtl/fio_rx_fifo.sv | 96 +++++++++
 tb/tb_fio_rx_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fio_pkg.sv
// Shared constants for the file I/O peripheral input path.
//   FIO_BYTE_W        : width of one stream byte
//   FIO_EMPTY_BYTE    : value presented on fio_din while the buffer is empty
//   FIO_DEPTH_DEFAULT : default receive buffer depth (entries)
//   FIO_AW_DEFAULT    : pointer width matching FIO_DEPTH_DEFAULT
//   FIO_STATS_W       : width of the optional accepted-byte counter
package fio_pkg;

  localparam int unsigned FIO_BYTE_W        = 8;
  localparam logic [FIO_BYTE_W-1:0] FIO_EMPTY_BYTE = 8'hFF;
  localparam int unsigned FIO_DEPTH_DEFAULT = 16;
  localparam int unsigned FIO_AW_DEFAULT    = $clog2(FIO_DEPTH_DEFAULT);
  localparam int unsigned FIO_STATS_W       = 16;

endpackage : fio_pkg

// File: rtl/fio_byte_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count.
// Ports:
//   mclk, puc_rst : clock, synchronous active-high reset
//   flush         : synchronous clear of pointers and level (contents kept)
//   push, wdata   : write request and data; ignored when full
//   pop           : read request; ignored when empty
//   rdata         : entry at the read pointer (combinational)
//   level         : registered occupancy 0..DEPTH
//   full, empty   : decoded from level
module fio_byte_fifo
  import fio_pkg::*;
#(
  parameter int unsigned DEPTH = FIO_DEPTH_DEFAULT,
  parameter int unsigned AW    = FIO_AW_DEFAULT,
  parameter int unsigned W     = FIO_BYTE_W
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; never reset, written only on an accepted push.
  always_ff @(posedge mclk) begin
    if (push_ok && !flush && !puc_rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at AW bits; level tracks the difference.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule : fio_byte_fifo

// File: rtl/fio_rx_fifo.sv
// Receive-side byte buffer for the file I/O peripheral. Host bytes enter on a
// valid/ready handshake; the head byte is offered to the peripheral, and one
// byte is consumed per rising edge of fio_dnxt.
// Ports:
//   mclk, puc_rst        : clock, synchronous active-high reset
//   rx_data, rx_valid    : host byte and its valid
//   rx_ready             : buffer not full (from registered level only)
//   flush                : synchronous clear of buffered bytes
//   fio_din, fio_dready  : head byte (8'hFF when empty) and non-empty flag
//   fio_dnxt             : read acknowledge, edge-detected
//   level                : current occupancy
// Optional (FIO_RX_STATS_EN defined):
//   rx_total             : saturating count of accepted host bytes
//   pop_empty_err        : sticky, read acknowledge seen while empty
module fio_rx_fifo
  import fio_pkg::*;
#(
  parameter int unsigned DEPTH = FIO_DEPTH_DEFAULT,
  parameter int unsigned AW    = FIO_AW_DEFAULT
) (
  input  logic                  mclk,
  input  logic                  puc_rst,
  input  logic [FIO_BYTE_W-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  flush,
  output logic [FIO_BYTE_W-1:0] fio_din,
  output logic                  fio_dready,
  input  logic                  fio_dnxt,
  output logic [AW:0]           level
`ifdef FIO_RX_STATS_EN
  ,
  output logic [FIO_STATS_W-1:0] rx_total,
  output logic                   pop_empty_err
`endif
);

  logic                  dnxt_q;
  logic                  dnxt_rise;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIO_BYTE_W-1:0] head;

  assign rx_ready  = ~fifo_full;
  assign push      = rx_valid & rx_ready;
  assign dnxt_rise = fio_dnxt & ~dnxt_q;
  // An edge arriving while empty is consumed here and never replayed.
  assign pop       = dnxt_rise & ~fifo_empty;

  // Rising-edge detector history for the read acknowledge.
  always_ff @(posedge mclk) begin
    if (puc_rst) dnxt_q <= 1'b0;
    else         dnxt_q <= fio_dnxt;
  end

  fio_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (FIO_BYTE_W)
  ) u_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .flush   (flush),
    .push    (push),
    .wdata   (rx_data),
    .pop     (pop),
    .rdata   (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Empty buffer shows a fixed idle byte; fio_dready tells it apart from data.
  assign fio_dready = ~fifo_empty;
  assign fio_din    = fifo_empty ? FIO_EMPTY_BYTE : head;

`ifdef FIO_RX_STATS_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      rx_total      <= '0;
      pop_empty_err <= 1'b0;
    end else begin
      if (push && !flush && (rx_total != '1)) begin
        rx_total <= rx_total + FIO_STATS_W'(1);
      end
      if (dnxt_rise && fifo_empty) begin
        pop_empty_err <= 1'b1;
      end
    end
  end
`endif

endmodule : fio_rx_fifo

// File: tb/tb_fio_rx_fifo.sv
// Directed self-checking bench for fio_rx_fifo.
module tb_fio_rx_fifo;

  logic       mclk;
  logic       puc_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       flush;
  logic [7:0] fio_din;
  logic       fio_dready;
  logic       fio_dnxt;
  logic [4:0] level;
`ifdef FIO_RX_STATS_EN
  logic [15:0] rx_total;
  logic        pop_empty_err;
`endif

  int checks = 0;
  int errors = 0;
  int exp_total = 0;

  fio_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .flush      (flush),
    .fio_din    (fio_din),
    .fio_dready (fio_dready),
    .fio_dnxt   (fio_dnxt),
    .level      (level)
`ifdef FIO_RX_STATS_EN
    ,
    .rx_total      (rx_total),
    .pop_empty_err (pop_empty_err)
`endif
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    exp_total++;
  endtask

  task automatic pop1();
    fio_dnxt = 1'b1;
    tick();
    fio_dnxt = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_b;

    puc_rst  = 1'b1;
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    flush    = 1'b0;
    fio_dnxt = 1'b0;
    #1;
    tick();
    tick();
    puc_rst  = 1'b0;
    rx_valid = 1'b0;

    // Reset state; the byte offered during reset must not be taken.
    chk("rst_level",  32'(level), 32'd0);
    chk("rst_ready",  32'(rx_ready), 32'd1);
    chk("rst_dready", 32'(fio_dready), 32'd0);
    chk("rst_din",    32'(fio_din), 32'hFF);
`ifdef FIO_RX_STATS_EN
    chk("rst_total",  32'(rx_total), 32'd0);
    chk("rst_perr",   32'(pop_empty_err), 32'd0);
`endif

    // Single push latency.
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    chk("push_cyc_dready", 32'(fio_dready), 32'd0);
    tick();
    rx_valid = 1'b0;
    exp_total++;
    chk("push_dready", 32'(fio_dready), 32'd1);
    chk("push_din",    32'(fio_din), 32'h41);
    chk("push_level",  32'(level), 32'd1);
    pop1();
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_din",   32'(fio_din), 32'hFF);

    // Fill to full, then hold a 17th byte valid.
    for (int i = 0; i < 16; i++) push1(8'(i));
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(rx_ready), 32'd0);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tick();
    tick();
    chk("full_hold_level", 32'(level), 32'd16);
    chk("full_head", 32'(fio_din), 32'h00);
    // Pop while full: no push this cycle, slot taken next cycle.
    fio_dnxt = 1'b1;
    tick();
    fio_dnxt = 1'b0;
    chk("full_pop_level", 32'(level), 32'd15);
    chk("full_pop_ready", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
    exp_total++;
    chk("refill_level", 32'(level), 32'd16);
    for (int i = 1; i < 17; i++) begin
      exp_b = (i < 16) ? 8'(i) : 8'hAA;
      chk("drain_din", 32'(fio_din), 32'(exp_b));
      pop1();
    end
    chk("drain_level",  32'(level), 32'd0);
    chk("drain_dready", 32'(fio_dready), 32'd0);

    // Held acknowledge pops exactly once.
    push1(8'hB0);
    push1(8'hB1);
    push1(8'hB2);
    chk("hold_pre_level", 32'(level), 32'd3);
    fio_dnxt = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_level", 32'(level), 32'd2);
    chk("hold_din",   32'(fio_din), 32'hB1);
    fio_dnxt = 1'b0;
    tick();
    pop1();
    chk("hold2_level", 32'(level), 32'd1);
    chk("hold2_din",   32'(fio_din), 32'hB2);
    pop1();
    chk("hold3_level", 32'(level), 32'd0);

    // Acknowledge on empty is dropped, not held for a later byte.
    pop1();
    chk("emp_pop_level", 32'(level), 32'd0);
    push1(8'h55);
    tick();
    chk("emp_push_level", 32'(level), 32'd1);
    chk("emp_push_din",   32'(fio_din), 32'h55);
`ifdef FIO_RX_STATS_EN
    chk("emp_perr", 32'(pop_empty_err), 32'd1);
`endif
    pop1();

    // Flush with a concurrent host byte.
    for (int i = 0; i < 5; i++) push1(8'h60 + 8'(i));
    chk("pre_flush_level", 32'(level), 32'd5);
    flush    = 1'b1;
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick();
    flush    = 1'b0;
    rx_valid = 1'b0;
    chk("flush_level",  32'(level), 32'd0);
    chk("flush_dready", 32'(fio_dready), 32'd0);
    chk("flush_din",    32'(fio_din), 32'hFF);
`ifdef FIO_RX_STATS_EN
    chk("flush_total", 32'(rx_total), 32'(exp_total));
`endif
    push1(8'h12);
    chk("post_flush_level", 32'(level), 32'd1);
    chk("post_flush_din",   32'(fio_din), 32'h12);
    pop1();

    // Simultaneous push and pop at level 2 over 40 cycles.
    push1(8'hC0);
    push1(8'hC1);
    for (int j = 0; j < 20; j++) begin
      chk("stream_din", 32'(fio_din), 32'(8'hC0 + 8'(j)));
      rx_data  = 8'hC0 + 8'(j + 2);
      rx_valid = 1'b1;
      fio_dnxt = 1'b1;
      tick();
      rx_valid = 1'b0;
      fio_dnxt = 1'b0;
      exp_total++;
      chk("stream_level_a", 32'(level), 32'd2);
      tick();
      chk("stream_level_b", 32'(level), 32'd2);
    end
    chk("stream_tail", 32'(fio_din), 32'hD4);
`ifdef FIO_RX_STATS_EN
    chk("final_total", 32'(rx_total), 32'(exp_total));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fio_rx_fifo
